// File: rtl/led_pattern_engine_pkg.sv
// Shared definitions for the LED pattern engine.
//   mode_e        : 2-bit display mode codes (BLINK/SHIFT/BOUNCE/COUNT)
//   mode_init_bit : value of led[0] when a mode is (re)loaded; all other
//                   bits of the initial pattern are zero.
package led_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_BLINK  = 2'd0,
    MODE_SHIFT  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_COUNT  = 2'd3
  } mode_e;

  // SHIFT and BOUNCE start one-hot at bit 0; BLINK and COUNT start all-zero.
  function automatic logic mode_init_bit(input mode_e m);
    return (m == MODE_SHIFT) || (m == MODE_BOUNCE);
  endfunction

endpackage

// File: rtl/led_pattern_engine_if.sv
// Control/status bundle of the LED pattern engine.
//   master : drives the one-shot key pulses and mode request, reads status
//   slave  : the engine itself
// Signals: faster, slower, pause, mode_load (1-cycle pulses), mode_sel[1:0],
//          led[N_LEDS-1:0], delay[DELAY_W-1:0], running, step.
interface led_pattern_engine_if #(
  parameter int N_LEDS  = 4,
  parameter int DELAY_W = 4
);

  logic               faster;
  logic               slower;
  logic               pause;
  logic [1:0]         mode_sel;
  logic               mode_load;
  logic [N_LEDS-1:0]  led;
  logic [DELAY_W-1:0] delay;
  logic               running;
  logic               step;

  modport master (
    output faster, slower, pause, mode_sel, mode_load,
    input  led, delay, running, step
  );

  modport slave (
    input  faster, slower, pause, mode_sel, mode_load,
    output led, delay, running, step
  );

endinterface

// File: rtl/led_pattern_engine_tick_gen.sv
// Base-tick prescaler for the LED pattern engine.
// Counts 0..PRESCALE-1 while en=1 and pulses tick for the single cycle the
// count sits at PRESCALE-1. With en=0 the count holds. clr returns the count
// to 0 and suppresses tick that cycle.
// Ports: clk, reset_n (async active-low), en, clr, tick.
module tick_gen #(
  parameter int PRESCALE = 5000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick = en && !clr && (cnt_q == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      if (cnt_q == LAST) cnt_q <= '0;
      else               cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_pattern_engine.sv
// N-LED pattern generator with programmable step period, four display modes
// and a run/pause toggle.
// Ports: clk, reset_n (async active-low), bus (led_pattern_engine_if.slave):
//   faster/slower adjust delay (saturating 1..2**DELAY_W-1), pause toggles
//   running, mode_load switches to mode_sel and restarts the pattern.
//   led, delay, running, step are registered.
//
// mode        | meaning
// ------------+--------------------------------------------------
// MODE_BLINK  | invert all LEDs each step, starts all-0
// MODE_SHIFT  | rotate left by one each step, starts at bit 0
// MODE_BOUNCE | one-hot ping-pong between bit 0 and bit N_LEDS-1
// MODE_COUNT  | binary up-count modulo 2**N_LEDS, starts at 0
module led_pattern_engine
  import led_pattern_pkg::*;
#(
  parameter int N_LEDS     = 4,
  parameter int DELAY_W    = 4,
  parameter int DELAY_INIT = 8,
  parameter int PRESCALE   = 5000000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  led_pattern_engine_if.slave  bus
);

  localparam logic [DELAY_W-1:0] DELAY_MAX = '1;
  localparam logic [DELAY_W-1:0] DELAY_RST = DELAY_W'(DELAY_INIT);
  localparam logic [DELAY_W-1:0] ONE       = DELAY_W'(1);

  mode_e              mode_q;
  logic [N_LEDS-1:0]  led_q;
  logic               dir_up_q;
  logic [DELAY_W-1:0] delay_q;
  logic [DELAY_W-1:0] step_cnt_q;
  logic               running_q;
  logic               step_q;

  logic               tick;
  logic [N_LEDS-1:0]  led_adv;
  logic               dir_adv;

  tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (running_q),
    .clr     (bus.mode_load),
    .tick    (tick)
  );

  // Next pattern if a step happens this cycle.
  always_comb begin
    led_adv = led_q;
    dir_adv = dir_up_q;
    unique case (mode_q)
      MODE_BLINK: led_adv = ~led_q;
      // Rotate built from shifts so a single LED simply holds.
      MODE_SHIFT: led_adv = (led_q << 1) | (led_q >> (N_LEDS - 1));
      MODE_BOUNCE: begin
        if (N_LEDS > 1) begin
          // Turn around while sitting on an end bit so the ends are not held
          // for an extra step.
          if (dir_up_q) begin
            if (led_q[N_LEDS-1]) begin
              led_adv = led_q >> 1;
              dir_adv = 1'b0;
            end else begin
              led_adv = led_q << 1;
            end
          end else begin
            if (led_q[0]) begin
              led_adv = led_q << 1;
              dir_adv = 1'b1;
            end else begin
              led_adv = led_q >> 1;
            end
          end
        end
      end
      MODE_COUNT: led_adv = led_q + N_LEDS'(1);
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q     <= MODE_SHIFT;
      led_q      <= N_LEDS'(1);
      dir_up_q   <= 1'b1;
      delay_q    <= DELAY_RST;
      step_cnt_q <= '0;
      running_q  <= 1'b1;
      step_q     <= 1'b0;
    end else begin
      // Opposing requests in one cycle cancel.
      if (bus.faster && !bus.slower && (delay_q != ONE))
        delay_q <= delay_q - ONE;
      else if (bus.slower && !bus.faster && (delay_q != DELAY_MAX))
        delay_q <= delay_q + ONE;

      if (bus.pause) running_q <= ~running_q;

      // mode_load outranks a step falling due on the same edge.
      if (bus.mode_load) begin
        mode_q     <= mode_e'(bus.mode_sel);
        led_q      <= N_LEDS'(mode_init_bit(mode_e'(bus.mode_sel)));
        dir_up_q   <= 1'b1;
        step_cnt_q <= '0;
        step_q     <= 1'b0;
      end else if (tick) begin
        // >= rather than == so shrinking delay below the current count
        // fires on the next tick instead of wrapping the counter.
        if (step_cnt_q >= (delay_q - ONE)) begin
          step_cnt_q <= '0;
          step_q     <= 1'b1;
          led_q      <= led_adv;
          dir_up_q   <= dir_adv;
        end else begin
          step_cnt_q <= step_cnt_q + ONE;
          step_q     <= 1'b0;
        end
      end else begin
        step_q <= 1'b0;
      end
    end
  end

  assign bus.led     = led_q;
  assign bus.delay   = delay_q;
  assign bus.running = running_q;
  assign bus.step    = step_q;

endmodule

// File: tb/tb_led_pattern_engine.sv
module tb_led_pattern_engine;

  logic clk;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;
  int   n;

  led_pattern_engine_if #(.N_LEDS(4), .DELAY_W(4)) bus ();

  led_pattern_engine #(
    .N_LEDS     (4),
    .DELAY_W    (4),
    .DELAY_INIT (2),
    .PRESCALE   (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One-cycle pulse on the inputs, set and cleared on falling edges.
  task automatic drive(input logic f, input logic s, input logic p, input logic l,
                       input logic [1:0] sel);
    @(negedge clk);
    bus.faster = f; bus.slower = s; bus.pause = p; bus.mode_load = l; bus.mode_sel = sel;
    @(negedge clk);
    bus.faster = 0; bus.slower = 0; bus.pause = 0; bus.mode_load = 0;
  endtask

  // Count rising edges until step is seen (bounded).
  task automatic next_step(output int cnt);
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (bus.step !== 1'b1 && cnt < 200);
  endtask

  logic [3:0] bounce_exp [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
  logic [3:0] cnt_exp;

  initial begin
    reset_n = 1'b0;
    bus.faster = 0; bus.slower = 0; bus.pause = 0; bus.mode_load = 0; bus.mode_sel = 2'd0;
    #12 reset_n = 1'b1;
    #1;
    check("rst_led", bus.led, 4'b0001);
    check("rst_delay", bus.delay, 4'd2);
    check("rst_running", bus.running, 1'b1);
    check("rst_step", bus.step, 1'b0);

    // 1: first advances at edges 8 and 16
    repeat (7) @(posedge clk);
    #1;
    check("e7_led", bus.led, 4'b0001);
    check("e7_step", bus.step, 1'b0);
    @(posedge clk); #1;
    check("e8_led", bus.led, 4'b0010);
    check("e8_step", bus.step, 1'b1);
    @(posedge clk); #1;
    check("e9_step", bus.step, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    check("e16_led", bus.led, 4'b0100);
    check("e16_step", bus.step, 1'b1);

    // 2: BOUNCE sequence
    drive(0, 0, 0, 1, 2'd2);
    check("bounce_init", bus.led, 4'b0001);
    for (int i = 0; i < 7; i++) begin
      next_step(n);
      check("bounce_period", n, 8);
      check("bounce_led", bus.led, bounce_exp[i]);
    end

    // 3: delay saturation
    drive(1, 0, 0, 0, 2'd0);
    check("faster1", bus.delay, 4'd1);
    drive(1, 0, 0, 0, 2'd0);
    check("faster_sat_a", bus.delay, 4'd1);
    drive(1, 0, 0, 0, 2'd0);
    check("faster_sat_b", bus.delay, 4'd1);
    next_step(n);
    next_step(n);
    check("period_d1", n, 4);
    for (int i = 0; i < 20; i++) drive(0, 1, 0, 0, 2'd0);
    check("slower_sat", bus.delay, 4'd15);
    drive(1, 1, 0, 0, 2'd0);
    check("both_nochange", bus.delay, 4'd15);
    for (int i = 0; i < 13; i++) drive(1, 0, 0, 0, 2'd0);
    check("delay_back_2", bus.delay, 4'd2);

    // 4: pause mid-period, remaining count preserved
    drive(0, 0, 0, 1, 2'd1);
    check("shift_init", bus.led, 4'b0001);
    repeat (3) @(posedge clk);
    drive(0, 0, 1, 0, 2'd0);
    check("paused", bus.running, 1'b0);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      check("frozen_led", bus.led, 4'b0001);
      check("frozen_step", bus.step, 1'b0);
    end
    drive(0, 1, 0, 0, 2'd0);
    check("pause_slower", bus.delay, 4'd3);
    drive(1, 0, 0, 0, 2'd0);
    check("pause_faster", bus.delay, 4'd2);
    drive(0, 0, 1, 0, 2'd0);
    check("resumed", bus.running, 1'b1);
    next_step(n);
    check("resume_remaining", n, 4);
    check("resume_led", bus.led, 4'b0010);
    next_step(n);
    check("resume_period", n, 8);
    check("resume_led2", bus.led, 4'b0100);

    // mode_load together with pause: BLINK loaded, now paused
    drive(0, 0, 1, 1, 2'd0);
    check("loadpause_run", bus.running, 1'b0);
    check("loadpause_led", bus.led, 4'b0000);
    repeat (10) @(posedge clk);
    #1;
    check("loadpause_hold", bus.led, 4'b0000);
    drive(0, 0, 1, 0, 2'd0);
    next_step(n);
    check("blink_period", n, 8);
    check("blink_led", bus.led, 4'b1111);

    // 5: mode_load on the edge a step is due
    repeat (7) @(posedge clk);
    drive(0, 0, 0, 1, 2'd3);
    check("clash_led", bus.led, 4'b0000);
    check("clash_step", bus.step, 1'b0);
    next_step(n);
    check("clash_period", n, 8);
    check("count_first", bus.led, 4'b0001);
    drive(1, 0, 0, 0, 2'd0);
    cnt_exp = 4'b0001;
    for (int i = 0; i < 15; i++) begin
      next_step(n);
      check("count_step_seen", bus.step, 1'b1);
      cnt_exp = cnt_exp + 4'd1;
      check("count_led", bus.led, cnt_exp);
    end

    // 6: async reset mid-BOUNCE going down, while paused
    drive(0, 0, 0, 1, 2'd2);
    for (int i = 0; i < 4; i++) begin
      next_step(n);
      check("b2_period", n, 4);
      check("b2_led", bus.led, bounce_exp[i]);
    end
    drive(0, 0, 1, 0, 2'd0);
    check("b2_paused", bus.running, 1'b0);
    check("b2_hold", bus.led, 4'b0100);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_led", bus.led, 4'b0001);
    check("async_delay", bus.delay, 4'd2);
    check("async_running", bus.running, 1'b1);
    check("async_step", bus.step, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    next_step(n);
    check("rerun_first", n, 8);
    check("rerun_led", bus.led, 4'b0010);
    next_step(n);
    check("rerun_period", n, 8);
    check("rerun_led2", bus.led, 4'b0100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
